// File: rtl/alu_arbiter_if.sv
// ----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the two requester channels and the shared-ALU connection of
// alu_arbiter.
//   Requester i (i = 0,1):
//     req_i            request; held high with op/a/b stable until gnt_i
//     op_i[3:0]        ALU opcode (0 AND, 1 OR, 2 ADD, other SUB)
//     a_i[31:0]        first operand
//     b_i[31:0]        second operand
//     gnt_i            one-cycle pulse: request accepted
//     rvalid_i         result valid
//     rdata_i[31:0]    result
//     rready_i         requester consumes the result
//   Shared ALU:
//     alu1[31:0]       first operand to the ALU
//     alu2[31:0]       second operand to the ALU
//     ALUop[3:0]       opcode to the ALU
//     aluout[31:0]     result from the ALU
//   Status:
//     busy             arbiter is not idle
// The master modport is the requester/ALU side; the slave modport is the
// arbiter.
// ----------------------------------------------------------------------------
interface alu_arbiter_if;
    logic        req_0;
    logic        req_1;
    logic [3:0]  op_0;
    logic [3:0]  op_1;
    logic [31:0] a_0;
    logic [31:0] a_1;
    logic [31:0] b_0;
    logic [31:0] b_1;
    logic        gnt_0;
    logic        gnt_1;
    logic        rvalid_0;
    logic        rvalid_1;
    logic [31:0] rdata_0;
    logic [31:0] rdata_1;
    logic        rready_0;
    logic        rready_1;
    logic [31:0] alu1;
    logic [31:0] alu2;
    logic [3:0]  ALUop;
    logic [31:0] aluout;
    logic        busy;

    modport master (
        output req_0, req_1, op_0, op_1, a_0, a_1, b_0, b_1,
        output rready_0, rready_1, aluout,
        input  gnt_0, gnt_1, rvalid_0, rvalid_1, rdata_0, rdata_1,
        input  alu1, alu2, ALUop, busy
    );

    modport slave (
        input  req_0, req_1, op_0, op_1, a_0, a_1, b_0, b_1,
        input  rready_0, rready_1, aluout,
        output gnt_0, gnt_1, rvalid_0, rvalid_1, rdata_0, rdata_1,
        output alu1, alu2, ALUop, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
// Shares one external ALU between two requesters. A transaction runs
// IDLE -> EXEC -> RESP -> IDLE: in IDLE a round-robin winner is picked and its
// operands latched; EXEC presents them to the ALU and captures aluout into the
// winner's rdata register; RESP holds rvalid until the winner's rready.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    alu_arbiter_if.slave (requester channels, shared ALU, busy)
// All outputs come straight from registers.
// ----------------------------------------------------------------------------
module alu_arbiter (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        win_q, win_d;      // index of the requester being served
    logic        last_q, last_d;    // most recently granted requester
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  rvalid_q, rvalid_d;
    logic        busy_q, busy_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        win_sel_s;
    logic        rready_win_s;

    // Round-robin pick: a lone request wins; a tie goes to the requester
    // that was not granted most recently.
    always_comb begin
        win_sel_s = 1'b0;
        if (bus.req_0 && bus.req_1) begin
            win_sel_s = ~last_q;
        end else if (bus.req_1) begin
            win_sel_s = 1'b1;
        end else begin
            win_sel_s = 1'b0;
        end
    end

    // Only the current winner's rready can close a response.
    always_comb begin
        rready_win_s = 1'b0;
        if (win_q) begin
            rready_win_s = bus.rready_1;
        end else begin
            rready_win_s = bus.rready_0;
        end
    end

    // Next-state logic, operand latching, result capture and output decode.
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        last_d   = last_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            IDLE: begin
                if (bus.req_0 || bus.req_1) begin
                    win_d   = win_sel_s;
                    last_d  = win_sel_s;
                    op_d    = win_sel_s ? bus.op_1 : bus.op_0;
                    a_d     = win_sel_s ? bus.a_1  : bus.a_0;
                    b_d     = win_sel_s ? bus.b_1  : bus.b_0;
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                // aluout reflects the latched operands during this cycle.
                if (win_q) begin
                    rdata1_d = bus.aluout;
                end else begin
                    rdata0_d = bus.aluout;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rready_win_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Output flags are registered from the next state so they line up
        // exactly with the state they describe.
        gnt_d    = {(state_d == EXEC) &&  win_d, (state_d == EXEC) && !win_d};
        rvalid_d = {(state_d == RESP) &&  win_d, (state_d == RESP) && !win_d};
        busy_d   = (state_d != IDLE);
    end

    // State, latched operands, results and output flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            win_q    <= 1'b0;
            last_q   <= 1'b1;
            op_q     <= 4'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            gnt_q    <= 2'b00;
            rvalid_q <= 2'b00;
            busy_q   <= 1'b0;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            last_q   <= last_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            busy_q   <= busy_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign bus.gnt_0    = gnt_q[0];
    assign bus.gnt_1    = gnt_q[1];
    assign bus.rvalid_0 = rvalid_q[0];
    assign bus.rvalid_1 = rvalid_q[1];
    assign bus.rdata_0  = rdata0_q;
    assign bus.rdata_1  = rdata1_q;
    assign bus.alu1     = a_q;
    assign bus.alu2     = b_q;
    assign bus.ALUop    = op_q;
    assign bus.busy     = busy_q;

endmodule
